// File: rtl/meter_display_if.sv
// -----------------------------------------------------------------------------
// meter_display_if
// Bundles the meter-side input word and the board-side display pins of
// meter_display.
//   count [15:0] : meter value in seconds (driven by the meter / master)
//   an    [3:0]  : digit anodes, active-low, an[0] = ones digit
//   seg   [6:0]  : segments {g,f,e,d,c,b,a}, active-low
//   dp           : decimal point, active-low (held off)
// Modports:
//   master : owns count, observes the display pins
//   slave  : the display driver (meter_display)
// -----------------------------------------------------------------------------
interface meter_display_if;
    logic [15:0] count;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (output count, input an, input seg, input dp);
    modport slave  (input count, output an, output seg, output dp);
endinterface

// File: rtl/meter_display.sv
// -----------------------------------------------------------------------------
// meter_display
// Converts the 16-bit meter seconds value to four BCD digits with a
// continuously running shift-add-3 engine (LOAD, 16 x SHIFT, DONE = 18 cycles)
// and scans them onto a 4-digit active-low seven-segment display with the
// meter blink policy: 1 Hz flash at zero, 0.5 Hz flash below BLINK_THRESH,
// steady otherwise.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   bus.count  : meter value (input, clamped to 9999)
//   bus.an     : digit anodes, active-low, registered
//   bus.seg    : segments {g,f,e,d,c,b,a}, active-low, registered
//   bus.dp     : decimal point, constant 1 (off)
//
// Parameters:
//   CLK_HZ       : clock frequency; the blink phase advances every CLK_HZ/2
//   REFRESH_DIV  : clock cycles each digit is driven
//   BLINK_THRESH : values in (0, BLINK_THRESH) flash at 0.5 Hz
//
// Build option:
//   METER_DISPLAY_LZB_EN : leading-zero blanking (ones digit never blanked)
// -----------------------------------------------------------------------------
module meter_display #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLINK_THRESH = 200
) (
    input  logic           clk,
    input  logic           reset,
    meter_display_if.slave bus
);

    typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_DONE} state_t;
    typedef enum logic [1:0] {MODE_ZERO, MODE_LOW, MODE_STEADY} mode_t;

    localparam int                TICK_N    = CLK_HZ / 2;
    localparam int                TICK_W    = (TICK_N > 1) ? $clog2(TICK_N) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_N - 1);
    localparam int                REF_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [15:0]       CLAMP_MAX = 16'd9999;
    localparam logic [15:0]       THRESH    = 16'(BLINK_THRESH);

    state_t            r_state;
    state_t            w_state_next;
    logic [15:0]       r_bin;
    logic [15:0]       r_bcd;
    logic [15:0]       r_value;
    logic [3:0]        r_bit_cnt;
    logic [15:0]       r_disp_digits;
    mode_t             r_disp_mode;
    logic [TICK_W-1:0] r_tick;
    logic [1:0]        r_phase;
    logic [REF_W-1:0]  r_refresh;
    logic [1:0]        r_digit_idx;
    logic [3:0]        r_an;
    logic [6:0]        r_seg;

    logic [15:0]       w_clamped;
    logic [15:0]       w_bcd_adj;
    mode_t             w_mode;
    logic              w_visible;
    logic              w_blank;
    logic [3:0]        w_digit;
    logic [6:0]        w_seg_dec;

    assign w_clamped = (bus.count > CLAMP_MAX) ? CLAMP_MAX : bus.count;

    // Add-3 correction on every BCD nibble ahead of the shift.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_add3
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                          r_bcd[gi*4 +: 4] + 4'd3 :
                                          r_bcd[gi*4 +: 4];
        end
    endgenerate

    // Mode comes from the value actually converted, so digits and mode
    // always describe the same sample.
    assign w_mode = (r_value == 16'd0) ? MODE_ZERO :
                    (r_value < THRESH) ? MODE_LOW  : MODE_STEADY;

    // ---------------- converter FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_LOAD;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_LOAD:  w_state_next = ST_SHIFT;
            ST_SHIFT: if (r_bit_cnt == 4'd15) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_LOAD;
            default:  w_state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin         <= 16'd0;
            r_bcd         <= 16'd0;
            r_value       <= 16'd0;
            r_bit_cnt     <= 4'd0;
            r_disp_digits <= 16'd0;
            r_disp_mode   <= MODE_ZERO;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    r_bin     <= w_clamped;
                    r_value   <= w_clamped;
                    r_bcd     <= 16'd0;
                    r_bit_cnt <= 4'd0;
                end
                ST_SHIFT: begin
                    r_bcd     <= {w_bcd_adj[14:0], r_bin[15]};
                    r_bin     <= {r_bin[14:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                ST_DONE: begin
                    // Digits and mode land together: no tearing on the display.
                    r_disp_digits <= r_bcd;
                    r_disp_mode   <= w_mode;
                end
                default: ;
            endcase
        end
    end

    // ---------------- blink phase and digit scan ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick      <= '0;
            r_phase     <= 2'd0;
            r_refresh   <= '0;
            r_digit_idx <= 2'd0;
        end else begin
            if (r_tick == TICK_LAST) begin
                r_tick  <= '0;
                r_phase <= r_phase + 2'd1;
            end else begin
                r_tick  <= r_tick + TICK_W'(1);
            end
            if (r_refresh == REF_LAST) begin
                r_refresh   <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
            end else begin
                r_refresh   <= r_refresh + REF_W'(1);
            end
        end
    end

    always_comb begin
        w_visible = 1'b1;
        unique case (r_disp_mode)
            MODE_ZERO: w_visible = ~r_phase[0];
            MODE_LOW:  w_visible = ~r_phase[1];
            default:   w_visible = 1'b1;
        endcase
    end

    assign w_digit = r_disp_digits[{r_digit_idx, 2'b00} +: 4];

`ifdef METER_DISPLAY_LZB_EN
    // w_upper_zero[i]: digit i and every digit above it are zero.
    // Bit 0 is tied low so the ones digit always shows.
    logic [4:0] w_upper_zero;
    assign w_upper_zero[4] = 1'b1;
    assign w_upper_zero[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lzb
            assign w_upper_zero[gi] = w_upper_zero[gi+1] &&
                                      (r_disp_digits[gi*4 +: 4] == 4'd0);
        end
    endgenerate
    assign w_blank = w_upper_zero[r_digit_idx];
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_seg_dec = 7'b1111111;
        case (w_digit)
            4'd0: w_seg_dec = 7'b1000000;
            4'd1: w_seg_dec = 7'b1111001;
            4'd2: w_seg_dec = 7'b0100100;
            4'd3: w_seg_dec = 7'b0110000;
            4'd4: w_seg_dec = 7'b0011001;
            4'd5: w_seg_dec = 7'b0010010;
            4'd6: w_seg_dec = 7'b0000010;
            4'd7: w_seg_dec = 7'b1111000;
            4'd8: w_seg_dec = 7'b0000000;
            4'd9: w_seg_dec = 7'b0010000;
            default: w_seg_dec = 7'b1111111;
        endcase
    end

    // ---------------- registered output stage ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
        end else if (w_visible && !w_blank) begin
            r_an  <= ~(4'b0001 << r_digit_idx);
            r_seg <= w_seg_dec;
        end else begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_meter_display.sv
// -----------------------------------------------------------------------------
// tb_meter_display
// Directed bench for meter_display at CLK_HZ=40, REFRESH_DIV=4. Cycle n is the
// n-th rising edge after reset release (n=0 is the first); outputs are sampled
// on the following falling edge. Expected an/seg per cycle come from the
// display timeline: digit slot (n/4)%4, blink phase (n/20)%4, and the display
// register holding 0000/ZERO until the first conversion lands at edge 17.
// Build with +define+METER_DISPLAY_LZB_EN to check leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_meter_display;

    localparam int M_ZERO   = 0;
    localparam int M_LOW    = 1;
    localparam int M_STEADY = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_cyc;
    int   checks;
    int   errors;
    logic [3:0] e_an;
    logic [6:0] e_seg;

    meter_display_if u_if ();

    meter_display #(
        .CLK_HZ      (40),
        .REFRESH_DIV (4),
        .BLINK_THRESH(200)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (u_if)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: seg_of = 7'b1000000;
            4'd1: seg_of = 7'b1111001;
            4'd2: seg_of = 7'b0100100;
            4'd3: seg_of = 7'b0110000;
            4'd4: seg_of = 7'b0011001;
            4'd5: seg_of = 7'b0010010;
            4'd6: seg_of = 7'b0000010;
            4'd7: seg_of = 7'b1111000;
            4'd8: seg_of = 7'b0000000;
            4'd9: seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    // Expected pins after edge n, given the display contents d/mode before it.
    function automatic void model(input int n, input logic [15:0] d, input int mode,
                                  output logic [3:0] x_an, output logic [6:0] x_seg);
        int idx;
        int ph;
        bit vis;
        bit blank;
        idx = (n / 4) % 4;
        ph  = (n / 20) % 4;
        case (mode)
            M_ZERO:  vis = ((ph % 2) == 0);
            M_LOW:   vis = (ph < 2);
            default: vis = 1'b1;
        endcase
        blank = 1'b0;
`ifdef METER_DISPLAY_LZB_EN
        if (idx == 3 && d[15:12] == 4'd0) blank = 1'b1;
        if (idx == 2 && d[15:8]  == 8'd0) blank = 1'b1;
        if (idx == 1 && d[15:4]  == 12'd0) blank = 1'b1;
`endif
        x_an  = 4'b1111;
        x_seg = 7'b1111111;
        if (vis && !blank) begin
            x_an[idx] = 1'b0;
            x_seg     = seg_of(d[idx*4 +: 4]);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n_cyc = n_cyc + 1;
    endtask

    task automatic restart(input logic [15:0] cnt);
        reset = 1'b0;
        u_if.count = cnt;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n_cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        u_if.count = 16'd1234;
        repeat (3) @(negedge clk);
        checks++;
        if (u_if.an !== 4'b1111) begin
            errors++; $display("FAIL reset_an: got %b want 1111", u_if.an);
        end
        checks++;
        if (u_if.seg !== 7'b1111111) begin
            errors++; $display("FAIL reset_seg: got %b want 1111111", u_if.seg);
        end
        checks++;
        if (u_if.dp !== 1'b1) begin
            errors++; $display("FAIL reset_dp: got %b want 1", u_if.dp);
        end
        $display("[%0t] test_reset: outputs held at reset values", $time);
    endtask

    task automatic test_steady_1234();
        restart(16'd1234);
        for (int i = 0; i < 240; i++) begin
            step();
            if (n_cyc < 18) model(n_cyc, 16'h0000, M_ZERO, e_an, e_seg);
            else            model(n_cyc, 16'h1234, M_STEADY, e_an, e_seg);
            checks++;
            if (u_if.an !== e_an || u_if.seg !== e_seg) begin
                errors++;
                $display("FAIL steady_1234 n=%0d: an=%b seg=%b, want an=%b seg=%b",
                         n_cyc, u_if.an, u_if.seg, e_an, e_seg);
            end
            if (n_cyc >= 40) begin
                checks++;
                if (u_if.an === 4'b1111) begin
                    errors++; $display("FAIL steady_blanked n=%0d: an=%b want one-hot", n_cyc, u_if.an);
                end
            end
        end
        checks++;
        if (u_if.dp !== 1'b1) begin
            errors++; $display("FAIL steady_dp: got %b want 1", u_if.dp);
        end
        $display("[%0t] test_steady_1234: 240 cycles scanned", $time);
    endtask

    task automatic test_low_150();
        restart(16'd150);
        for (int i = 0; i < 120; i++) begin
            step();
            if (n_cyc < 18) model(n_cyc, 16'h0000, M_ZERO, e_an, e_seg);
            else            model(n_cyc, 16'h0150, M_LOW, e_an, e_seg);
            checks++;
            if (u_if.an !== e_an || u_if.seg !== e_seg) begin
                errors++;
                $display("FAIL low_150 n=%0d: an=%b seg=%b, want an=%b seg=%b",
                         n_cyc, u_if.an, u_if.seg, e_an, e_seg);
            end
        end
        $display("[%0t] test_low_150: 0.5 Hz flash window checked", $time);
    endtask

    task automatic test_zero_flash();
        restart(16'd0);
        for (int i = 0; i < 80; i++) begin
            step();
            model(n_cyc, 16'h0000, M_ZERO, e_an, e_seg);
            checks++;
            if (u_if.an !== e_an || u_if.seg !== e_seg) begin
                errors++;
                $display("FAIL zero_flash n=%0d: an=%b seg=%b, want an=%b seg=%b",
                         n_cyc, u_if.an, u_if.seg, e_an, e_seg);
            end
        end
        $display("[%0t] test_zero_flash: 1 Hz flash window checked", $time);
    endtask

    task automatic test_clamp();
        restart(16'd12000);
        for (int i = 0; i < 60; i++) begin
            step();
            if (n_cyc < 18) model(n_cyc, 16'h0000, M_ZERO, e_an, e_seg);
            else            model(n_cyc, 16'h9999, M_STEADY, e_an, e_seg);
            checks++;
            if (u_if.an !== e_an || u_if.seg !== e_seg) begin
                errors++;
                $display("FAIL clamp_12000 n=%0d: an=%b seg=%b, want an=%b seg=%b",
                         n_cyc, u_if.an, u_if.seg, e_an, e_seg);
            end
        end
        $display("[%0t] test_clamp: 12000 shown as 9999", $time);
    endtask

    // count goes 199 -> 200 right after edge 40; the LOAD at edge 54 picks it
    // up, DONE writes at edge 71, pins follow after edge 72 (within 36 cycles).
    task automatic test_threshold_step();
        restart(16'd199);
        for (int i = 0; i < 110; i++) begin
            step();
            if (n_cyc == 40) u_if.count = 16'd200;
            if (n_cyc < 18)      model(n_cyc, 16'h0000, M_ZERO, e_an, e_seg);
            else if (n_cyc < 72) model(n_cyc, 16'h0199, M_LOW, e_an, e_seg);
            else                 model(n_cyc, 16'h0200, M_STEADY, e_an, e_seg);
            checks++;
            if (u_if.an !== e_an || u_if.seg !== e_seg) begin
                errors++;
                $display("FAIL thresh_step n=%0d: an=%b seg=%b, want an=%b seg=%b",
                         n_cyc, u_if.an, u_if.seg, e_an, e_seg);
            end
        end
        $display("[%0t] test_threshold_step: 199 flash to 200 steady", $time);
    endtask

    task automatic test_reset_mid_scan();
        restart(16'd1234);
        for (int i = 0; i < 31; i++) step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (u_if.an !== 4'b1111 || u_if.seg !== 7'b1111111 || u_if.dp !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1",
                     u_if.an, u_if.seg, u_if.dp);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (u_if.an !== 4'b1111 || u_if.seg !== 7'b1111111) begin
            errors++;
            $display("FAIL reset_held: an=%b seg=%b, want an=1111 seg=1111111", u_if.an, u_if.seg);
        end
        reset = 1'b1;
        n_cyc = -1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (n_cyc < 18) model(n_cyc, 16'h0000, M_ZERO, e_an, e_seg);
            else            model(n_cyc, 16'h1234, M_STEADY, e_an, e_seg);
            checks++;
            if (u_if.an !== e_an || u_if.seg !== e_seg) begin
                errors++;
                $display("FAIL restart n=%0d: an=%b seg=%b, want an=%b seg=%b",
                         n_cyc, u_if.an, u_if.seg, e_an, e_seg);
            end
        end
        $display("[%0t] test_reset_mid_scan: async reset and restart checked", $time);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_cyc  = -1;
        reset  = 1'b0;
        u_if.count = 16'd0;
        test_reset();
        test_steady_1234();
        test_low_150();
        test_zero_flash();
        test_clamp();
        test_threshold_step();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/meter_display.md
# meter_display

Display-side consumer of the parking-meter `count` word. Takes the 16-bit seconds value from the meter, converts it to four BCD digits with a sequential shift-add-3 engine, and time-multiplexes those digits onto a 4-digit active-low seven-segment display. It applies the meter's blink policy: 1 Hz flash at zero, 0.5 Hz flash below the threshold, steady otherwise. It sits between the meter counter and the board's `an`/`seg` pins.

## Interface
- `CLK_HZ`, 100_000_000: input clock frequency; one half-second tick every `CLK_HZ/2` cycles.
- `REFRESH_DIV`, 100_000: clk cycles per digit slot (1 kHz digit step at default).
- `BLINK_THRESH`, 200: counts strictly below this and above 0 flash at 0.5 Hz.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `count` in 16: meter value in seconds, binary, unsigned.
- `an` out 4: digit anodes, active-low, one-hot when visible; `an[0]` is the ones digit.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low, constant 1 (off).

## Operation
- Clamp: a `count` value above 9999 is converted as 9999.
- The converter FSM is `LOAD -> SHIFT (16 cycles) -> DONE -> LOAD`, and it runs continuously.
  - `LOAD` samples the clamped `count` into the shift register and clears the BCD accumulator.
  - Each `SHIFT` cycle adds 3 to every BCD nibble ≥5, then shifts left by 1.
  - `DONE` writes all four BCD digits and the blink mode into the display register in one atomic write.
- Blink mode is decoded from the converted value, never from raw `count`:
  - value == 0: `ZERO`.
  - 0 < value < `BLINK_THRESH`: `LOW`.
  - Otherwise: `STEADY`.
- Half-second tick counter: counts 0..`CLK_HZ/2`-1 and then wraps. Each wrap increments a free-running 2-bit `phase`.
- Visibility rules:
  - `ZERO` is visible when `phase[0]==0`.
  - `LOW` is visible when `phase[1]==0`.
  - `STEADY` is always visible.
  - `phase` does not resync on a mode change.
- Refresh counter: counts 0..`REFRESH_DIV`-1. Each wrap advances digit index 0→1→2→3→0.
- Output stage:
  - Visible: `an` drives the index position low and `seg` drives the digit's decode.
  - Invisible: `an=4'b1111` and `seg=7'b1111111`.
- Decode table, digit 0–9: `1000000`, `1111001`, `0100100`, `0110000`, `0011001`, `0010010`, `0000010`, `1111000`, `0000000`, `0010000`.

## Timing
- Reset values: `an=4'b1111`, `seg=7'b1111111`, `dp=1`, display register 0 with mode `ZERO`, digit index 0, `phase=0`, both counters 0, FSM in `LOAD`.
- Conversion period is 18 cycles.
- A `count` change reaches the display register within 36 cycles.
- `an`/`seg` are registered. They reflect a new index, display value or visibility state one cycle after it changes.
- Each digit is driven for exactly `REFRESH_DIV` cycles, giving a full scan every `4*REFRESH_DIV` cycles.
- `count` changing during `SHIFT` has no effect until the next `LOAD`. No tearing between digits and mode.
- Reset assertion mid-scan or mid-conversion forces all outputs to their reset values immediately, with no clock required.
- After reset release, the first valid display write is on cycle 17. Until then the display shows `0000` in `ZERO` mode, visible because `phase=0`.

## Configuration
- `METER_DISPLAY_LZB_EN` defined: leading-zero blanking.
  - Any zero digit above the most significant nonzero digit gets `an` high and `seg=7'b1111111` during its slot.
  - The ones digit is never blanked.
- Undefined: all four digits are always driven when visible.

## Test plan
Sim parameters: `CLK_HZ=40`, `REFRESH_DIV=4`.
- `count=1234`, reset released, wait 40 cycles → per slot `an`/`seg` = `1110`/`0011001`, `1101`/`0110000`, `1011`/`0100100`, `0111`/`1111001`; never blanked over 200 cycles.
- `count=150` → digits 0,1,5,0 (thousands slot `an=1111` with `METER_DISPLAY_LZB_EN`).
  - Visible for the first 40 cycles of `phase`, blank for the next 40, and so on.
- `count=0` → ones slot `seg=1000000`; visible for 20 cycles, blank for 20, repeating.
  - With `METER_DISPLAY_LZB_EN`, the other three slots are blank.
- `count=12000` → displays 9999 steady (`seg=0010000` every slot).
- `count` stepped 199→200 → display changes from 0.5 Hz flash to steady within 36 cycles; digits read 0200 (LZB: 200).
- `reset` pulsed low mid-scan → `an=1111`, `seg=1111111`, `dp=1` in the same cycle.
  - After release, the scan restarts at `an[0]` and the first conversion lands at cycle 17.
